// File: rtl/fp_normalize_pack.sv
// fp_normalize_pack: normalises a raw mantissa-ALU result and packs it as IEEE-754 single precision
module fp_normalize_pack (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sign_in,
    input  logic [7:0]  exp_in,
    input  logic [23:0] mant_in,
    input  logic        carry_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        overflow,
    output logic        zero
);
    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
    state_t state, state_next;
    logic        sign_r;
    logic [7:0]  exp_r;
    logic [23:0] mant_r;
    logic        ovf_r;
    logic        accept;
    logic        norm_exit;
    logic [31:0] packed_word;
    assign in_ready    = state == IDLE;
    assign out_valid   = state == DONE;
    assign accept      = in_valid & in_ready;
    assign norm_exit   = ovf_r | (mant_r == 24'd0) | mant_r[23] | (exp_r <= 8'd1);
    assign packed_word = ovf_r             ? {sign_r, 8'hFF, 23'h0} :
                         mant_r == 24'd0   ? 32'h0 :
                         mant_r[23]        ? {sign_r, exp_r, mant_r[22:0]} :
                                             {sign_r, 8'h00, mant_r[22:0]};
    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end
    // next-state: accept in IDLE, shift in NORM until an exit condition, hand off in DONE
    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = in_valid  ? NORM : IDLE;
            NORM:    state_next = norm_exit ? DONE : NORM;
            DONE:    state_next = out_ready ? IDLE : DONE;
            default: state_next = IDLE;
        endcase
    end
    // datapath: capture operand (pre-shifting on carry), left-normalise, pack on exit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sign_r   <= 1'b0;
            exp_r    <= 8'd0;
            mant_r   <= 24'd0;
            ovf_r    <= 1'b0;
            result   <= 32'h0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else if (accept) begin
            sign_r   <= sign_in;
            mant_r   <= carry_in ? {1'b1, mant_in[23:1]} : mant_in;
            exp_r    <= exp_in + {7'd0, carry_in};
            ovf_r    <= carry_in & (exp_in >= 8'hFE);
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else if (state == NORM) begin
            if (norm_exit) begin
                result   <= packed_word;
                overflow <= ovf_r;
                zero     <= ~ovf_r & (mant_r == 24'd0);
            end else begin
                mant_r <= {mant_r[22:0], 1'b0};
                exp_r  <= exp_r - 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_fp_normalize_pack.sv
// tb_fp_normalize_pack: directed and random checks of fp_normalize_pack against an arithmetic model
module tb_fp_normalize_pack;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        sign_in = 1'b0;
    logic [7:0]  exp_in = 8'd0;
    logic [23:0] mant_in = 24'd0;
    logic        carry_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        overflow;
    logic        zero;
    int n_checks = 0;
    int n_fail = 0;

    fp_normalize_pack dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .sign_in(sign_in), .exp_in(exp_in), .mant_in(mant_in), .carry_in(carry_in),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: value = mant * 2^(exp-bias); normalise by leading-zero count, floored at exponent 1
    task automatic model(input logic s, input logic [7:0] e, input logic [23:0] m, input logic c,
                         output logic [31:0] r, output logic o, output logic z, output int lat);
        int ee, k, msb, lz;
        logic [23:0] mm;
        mm = c ? (m >> 1) + 24'h800000 : m;
        ee = int'(e) + int'(c);
        o = 1'b0;
        z = 1'b0;
        if (c && ee >= 255) begin
            o = 1'b1; r = {s, 8'hFF, 23'h0}; lat = 1;
        end else if (mm == 24'd0) begin
            z = 1'b1; r = 32'h0; lat = 1;
        end else begin
            msb = 0;
            for (int b = 0; b < 24; b++) if (mm[b]) msb = b;
            lz = 23 - msb;
            k = (ee > 1) ? ((lz < ee - 1) ? lz : ee - 1) : 0;
            mm = mm << k;
            ee = ee - k;
            r = mm[23] ? {s, ee[7:0], mm[22:0]} : {s, 8'h00, mm[22:0]};
            lat = k + 1;
        end
    endtask

    task automatic do_op(input logic s, input logic [7:0] e, input logic [23:0] m, input logic c, input int stall);
        logic [31:0] er;
        logic eo, ez;
        int el, n;
        model(s, e, m, c, er, eo, ez, el);
        n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk("in_ready_before", {31'd0, in_ready}, 32'd1);
        sign_in = s; exp_in = e; mant_in = m; carry_in = c; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
        chk("latency", n, el);
        chk("result", result, er);
        chk("overflow", {31'd0, overflow}, {31'd0, eo});
        chk("zero", {31'd0, zero}, {31'd0, ez});
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            mant_in = 24'($urandom);
            exp_in = 8'($urandom);
            @(posedge clk); #1;
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_result", result, er);
            chk("hold_flags", {30'd0, overflow, zero}, {30'd0, eo, ez});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("in_ready_after", {31'd0, in_ready}, 32'd1);
        chk("out_valid_after", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_result", result, 32'h0);
        chk("rst_flags", {30'd0, overflow, zero}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(1'b0, 8'h7F, 24'hC00000, 1'b1, 0);
        chk("carry_exact", result, 32'h40600000);
        do_op(1'b1, 8'h82, 24'h100000, 1'b0, 0);
        chk("leftnorm_exact", result, 32'hBF800000);
        do_op(1'b1, 8'h90, 24'h000000, 1'b0, 0);
        chk("cancel_exact", result, 32'h00000000);
        do_op(1'b0, 8'hFE, 24'h800000, 1'b1, 0);
        chk("ovf_exact", result, 32'h7F800000);
        do_op(1'b0, 8'h02, 24'h200000, 1'b0, 0);
        chk("subnorm_exact", result, 32'h00400000);
        do_op(1'b1, 8'h00, 24'h012345, 1'b0, 0);
        do_op(1'b0, 8'h85, 24'h0A0000, 1'b0, 5);
        // reset while normalising discards the operation
        sign_in = 1'b0; exp_in = 8'h80; mant_in = 24'h000001; carry_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("norm_busy", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_result", result, 32'h0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_flags", {30'd0, overflow, zero}, 32'd0);
        // reset wins over an accept on the same edge
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b1;
        chk("rst_prio_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        chk("rst_prio_out_valid", {31'd0, out_valid}, 32'd0);
        for (int t = 0; t < 60; t++) begin
            logic [23:0] m;
            logic [7:0] e;
            m = 24'($urandom) >> $urandom_range(0, 24);
            case ($urandom_range(0, 3))
                0:       e = 8'($urandom_range(0, 4));
                1:       e = 8'($urandom_range(250, 255));
                default: e = 8'($urandom);
            endcase
            do_op(1'($urandom), e, m, 1'($urandom), int'($urandom_range(0, 2)));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fp_normalize_pack.md
FP_NORMALIZE_PACK -- requirements
Module: fp_normalize_pack

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port in_valid, input, 1 bit: the upstream mantissa-ALU result is present.
REQ-004 SHALL have port in_ready, output, 1 bit: the block can accept a new operand set.
REQ-005 SHALL have port sign_in, input, 1 bit: sign of the result.
REQ-006 SHALL have port exp_in, input, 8 bits: biased exponent of the larger operand.
REQ-007 SHALL have port mant_in, input, 24 bits: raw mantissa sum or difference, hidden bit at [23].
REQ-008 SHALL have port carry_in, input, 1 bit: carry-out of the mantissa add.
REQ-009 SHALL have port out_valid, output, 1 bit: result is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 SHALL have port result, output, 32 bits: IEEE-754 single-precision packed result.
REQ-012 SHALL have port overflow, output, 1 bit: result saturated to infinity.
REQ-013 SHALL have port zero, output, 1 bit: result is exact zero.

Function
REQ-014 SHALL implement a state machine with the states IDLE, NORM and DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE; an accept occurs on an edge where in_valid=1 and in_ready=1, and in_valid is ignored in every other state.
REQ-016 SHALL, on accept, register sign_in, and go to NORM; if carry_in=1, SHALL register mant={1,mant_in[23:1]} and exp=exp_in+1 with the LSB truncated, otherwise SHALL register mant_in and exp_in unchanged.
REQ-017 SHALL, on accept with carry_in=1 and exp_in+1 >= 255, set an internal overflow flag.
REQ-018 SHALL, in NORM on each edge, go to DONE if (a) the overflow flag is set, (b) mant==0, (c) mant[23]==1, or (d) exp<=1; otherwise SHALL shift mant left 1 bit (zero-fill) and decrement exp by 1, staying in NORM.
REQ-019 SHALL, on entering DONE, register result as: overflow -> {sign,8'hFF,23'h0} with overflow=1; mant==0 -> 32'h00000000 with zero=1 (always +0); mant[23]==1 -> {sign,exp,mant[22:0]}; otherwise (subnormal) -> {sign,8'h00,mant[22:0]}.
REQ-020 SHALL assert out_valid only in DONE, and SHALL give a latency from the accept edge to out_valid of k+1 cycles, where k is the number of NORM shifts (0..23).
REQ-021 SHALL, in DONE with out_ready=0, hold result, overflow, zero and out_valid stable.
REQ-022 SHALL, in DONE with out_ready=1, go to IDLE on that edge; no accept occurs on that same edge, and in_ready rises on the following cycle.
REQ-023 SHALL clear overflow and zero on every accept.
REQ-024 SHALL handle exp_in=0 (subnormal inputs) through the exp<=1 exit with no shift.

Reset
REQ-025 SHALL, when rst_n=0 at a rising edge, set state=IDLE, out_valid=0, in_ready=1 (from the next cycle), result=32'h0, overflow=0, zero=0, and clear all internal mant, exp, sign and flag registers.
REQ-026 SHALL let reset abort any operation in NORM or DONE, discarding it with no output produced.
REQ-027 SHALL give reset priority over an accept or an out_ready handshake on the same edge.

Verification
REQ-028 SHALL cover the carry path: sign 0, exp_in 0x7F, mant_in 0xC00000, carry 1 -> result 0x40600000 (3.5), overflow 0, latency 1.
REQ-029 SHALL cover left normalisation: sign 1, exp_in 0x82, mant_in 0x100000, carry 0 -> 3 shifts, result 0xBF800000, out_valid 4 cycles after accept.
REQ-030 SHALL cover cancellation: sign 1, exp_in 0x90, mant_in 0x000000 -> result 0x00000000, zero 1, latency 1.
REQ-031 SHALL cover overflow: exp_in 0xFE, mant_in 0x800000, carry 1 -> result 0x7F800000, overflow 1.
REQ-032 SHALL cover the subnormal exit: exp_in 0x02, mant_in 0x200000 -> 1 shift, result 0x00400000, latency 2.
REQ-033 SHALL cover backpressure and reset: with out_ready=0 held 5 cycles, result and out_valid stay stable and in_valid pulses are ignored; rst_n=0 during NORM -> out_valid 0, result 0, in_ready 1 the next cycle.
